// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The optional val_out accumulator is enabled with the KEYPAD_ACCUM_EN macro.
package keypad_pkg;

    localparam int unsigned ROW_W = 4;
    localparam int unsigned COL_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned VAL_W = 16;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [ROW_W-1:0] ROW0     = 4'b1110;
    localparam logic [ROW_W-1:0] ROW1     = 4'b1101;
    localparam logic [ROW_W-1:0] ROW2     = 4'b1011;
    localparam logic [ROW_W-1:0] ROW3     = 4'b0111;
    localparam logic [COL_W-1:0] COL_NONE = 4'b1111;

    // Active-low row drive pattern for a row index.
    function automatic logic [ROW_W-1:0] row_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    return ROW0;
            2'd1:    return ROW1;
            2'd2:    return ROW2;
            default: return ROW3;
        endcase
    endfunction

endpackage

// File: rtl/keypad_col_enc.sv
// Active-low 4-bit priority encoder: lowest-index low column wins.
module keypad_col_enc
    import keypad_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [1:0]       col_idx,
    output logic             any_low
);

    always_comb begin
        any_low = (col_in != COL_NONE);
        col_idx = 2'd0;
        if (!col_in[0]) begin
            col_idx = 2'd0;
        end else if (!col_in[1]) begin
            col_idx = 2'd1;
        end else if (!col_in[2]) begin
            col_idx = 2'd2;
        end else if (!col_in[3]) begin
            col_idx = 2'd3;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce and key code output.
// Define KEYPAD_ACCUM_EN to build the four-digit hex accumulator on val_out.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smpl,
    input  logic [COL_W-1:0] col_in,
    input  logic             clr,
    output logic [ROW_W-1:0] row_sel,
    output logic [3:0]       key_code,
    output logic             key_vld,
    output logic             key_held,
    output logic [VAL_W-1:0] val_out
);

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CNT);

    kp_state_e        state;
    logic [1:0]       row_idx;
    logic [1:0]       col_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       col_idx;
    logic             any_low;

    keypad_col_enc u_col_enc (
        .col_in  (col_in),
        .col_idx (col_idx),
        .any_low (any_low)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    // Scan/debounce FSM; everything except the key_vld pulse moves only on smpl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            row_idx  <= 2'd0;
            row_sel  <= ROW0;
            col_lat  <= 2'd0;
            cnt      <= '0;
            key_code <= 4'd0;
            key_vld  <= 1'b0;
            key_held <= 1'b0;
        end else begin
            key_vld <= 1'b0;
            if (smpl) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            col_lat <= col_idx;
                            if (DB_LIMIT == CNT_W'(1)) begin
                                key_code <= {row_idx, col_idx};
                                key_vld  <= 1'b1;
                                key_held <= 1'b1;
                                cnt      <= '0;
                                state    <= HELD;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            row_sel <= row_drive(row_idx + 2'd1);
                        end
                    end
                    DEBOUNCE: begin
                        if (any_low && (col_idx == col_lat)) begin
                            if (cnt_inc == DB_LIMIT) begin
                                key_code <= {row_idx, col_lat};
                                key_vld  <= 1'b1;
                                key_held <= 1'b1;
                                cnt      <= '0;
                                state    <= HELD;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt     <= '0;
                            row_idx <= row_idx + 2'd1;
                            row_sel <= row_drive(row_idx + 2'd1);
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        // Extra keys while held are ignored; only all-high starts release.
                        if (col_in == COL_NONE) begin
                            if (DB_LIMIT == CNT_W'(1)) begin
                                key_held <= 1'b0;
                                cnt      <= '0;
                                row_idx  <= row_idx + 2'd1;
                                row_sel  <= row_drive(row_idx + 2'd1);
                                state    <= SCAN;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (col_in == COL_NONE) begin
                            if (cnt_inc == DB_LIMIT) begin
                                key_held <= 1'b0;
                                cnt      <= '0;
                                row_idx  <= row_idx + 2'd1;
                                row_sel  <= row_drive(row_idx + 2'd1);
                                state    <= SCAN;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= HELD;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

`ifdef KEYPAD_ACCUM_EN
    // Shift each accepted key in as the new low digit; clr wins over a same-cycle key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_out <= '0;
        end else if (clr) begin
            val_out <= '0;
        end else if (key_vld) begin
            val_out <= {val_out[VAL_W-5:0], key_code};
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign val_out    = '0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: DEBOUNCE_CNT=4 and DEBOUNCE_CNT=1 instances
// checked every clock against a run-length behavioural model.
module tb_keypad_scanner;

    localparam int DB0 = 4;
    localparam int DB1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smpl = 1'b0;
    logic [3:0]  col_in = 4'hF;
    logic        clr = 1'b0;

    logic [3:0]  rs0, code0, rs1, code1;
    logic        vld0, held0, vld1, held1;
    logic [15:0] val0, val1;

    int checks = 0;
    int failures = 0;

    // Model: per instance, current row, run length of matching samples, candidate column.
    int          m_row  [2];
    int          m_run  [2];
    int          m_cand [2];
    bit          m_held [2];
    bit          m_vld  [2];
    logic [3:0]  m_code [2];
    logic [15:0] m_val  [2];

    int vld_seen;

    always #5 clk = ~clk;

    keypad_scanner #(.DEBOUNCE_CNT(DB0)) dut0 (
        .clk(clk), .rst(rst), .smpl(smpl), .col_in(col_in), .clr(clr),
        .row_sel(rs0), .key_code(code0), .key_vld(vld0), .key_held(held0), .val_out(val0)
    );

    keypad_scanner #(.DEBOUNCE_CNT(DB1)) dut1 (
        .clk(clk), .rst(rst), .smpl(smpl), .col_in(col_in), .clr(clr),
        .row_sel(rs1), .key_code(code1), .key_vld(vld1), .key_held(held1), .val_out(val1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_row(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_row[k] = 0; m_run[k] = 0; m_cand[k] = 0; m_held[k] = 0;
            m_vld[k] = 0; m_code[k] = 4'd0; m_val[k] = 16'd0;
        end
    endtask

    // One clock edge of the behavioural model for instance k.
    task automatic m_edge(input int k, input bit s, input logic [3:0] col, input bit c);
        int db;
        int low;
        db = (k == 0) ? DB0 : DB1;
`ifdef KEYPAD_ACCUM_EN
        if (c) m_val[k] = 16'd0;
        else if (m_vld[k]) m_val[k] = {m_val[k][11:0], m_code[k]};
`else
        m_val[k] = 16'd0;
`endif
        m_vld[k] = 0;
        if (!s) return;
        low = -1;
        for (int i = 3; i >= 0; i--) if (!col[i]) low = i;
        if (!m_held[k]) begin
            if (low >= 0 && (m_run[k] == 0 || low == m_cand[k])) begin
                m_cand[k] = low;
                m_run[k]++;
                if (m_run[k] >= db) begin
                    m_code[k] = 4'(m_row[k] * 4 + low);
                    m_vld[k]  = 1;
                    m_held[k] = 1;
                    m_run[k]  = 0;
                end
            end else begin
                m_run[k] = 0;
                m_row[k] = (m_row[k] + 1) % 4;
            end
        end else if (col == 4'hF) begin
            m_run[k]++;
            if (m_run[k] >= db) begin
                m_held[k] = 0;
                m_run[k]  = 0;
                m_row[k]  = (m_row[k] + 1) % 4;
            end
        end else begin
            m_run[k] = 0;
        end
    endtask

    task automatic observe(input bit s, input logic [3:0] col, input bit c);
        m_edge(0, s, col, c);
        m_edge(1, s, col, c);
        if (vld0) vld_seen++;
        chk("row_sel_db4",  16'(rs0),   16'(exp_row(m_row[0])));
        chk("key_vld_db4",  16'(vld0),  16'(m_vld[0]));
        chk("key_held_db4", 16'(held0), 16'(m_held[0]));
        chk("key_code_db4", 16'(code0), 16'(m_code[0]));
        chk("val_out_db4",  val0,       m_val[0]);
        chk("row_sel_db1",  16'(rs1),   16'(exp_row(m_row[1])));
        chk("key_vld_db1",  16'(vld1),  16'(m_vld[1]));
        chk("key_held_db1", 16'(held1), 16'(m_held[1]));
        chk("key_code_db1", 16'(code1), 16'(m_code[1]));
        chk("val_out_db1",  val1,       m_val[1]);
    endtask

    task automatic tick(input bit s, input logic [3:0] col, input bit c);
        @(negedge clk);
        smpl = s; col_in = col; clr = c;
        @(posedge clk);
        #1;
        smpl = 1'b0; clr = 1'b0;
        observe(s, col, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_row_sel",  16'(rs0),   16'hE);
        chk("rst_key_held", 16'(held0), 16'h0);
        chk("rst_key_vld",  16'(vld0),  16'h0);
        chk("rst_key_code", 16'(code0), 16'h0);
        chk("rst_val_out",  val0,       16'h0);
        chk("rst_held_db1", 16'(held1), 16'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        observe(1'b0, 4'hF, 1'b0);
    endtask

    // Physical key: its column reads low only while its row is driven.
    function automatic logic [3:0] phys(input int key);
        logic [3:0] one;
        one = 4'b0001;
        if (m_row[0] == key / 4) return ~(one << (key % 4));
        return 4'hF;
    endfunction

    task automatic press(input int key);
        bit got;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick(1'b1, phys(key), 1'b0);
            got = m_vld[0];
        end
        chk("press_accepted", 16'(vld0), 16'h1);
    endtask

    task automatic release_key();
        for (int n = 0; n < 40 && m_held[0]; n++) tick(1'b1, 4'hF, 1'b0);
        chk("release_done", 16'(held0), 16'h0);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Idle scanning: row rotates, no key_vld.
        vld_seen = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, 4'hF, 1'b0);
        chk("idle_no_vld", 16'(vld_seen), 16'h0);
        chk("idle_row_wrap", 16'(rs0), 16'hE);

        // Row 2, column 1 held four samples -> code 9, then release resumes at row 3.
        tick(1'b1, 4'hF, 1'b0);
        tick(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b1101, 1'b0);
        chk("press9_vld", 16'(vld0), 16'h1);
        chk("press9_code", 16'(code0), 16'h9);
        chk("press9_held", 16'(held0), 16'h1);
        tick(1'b0, 4'b1101, 1'b0);
        chk("press9_vld_drop", 16'(vld0), 16'h0);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'hF, 1'b0);
        chk("rel9_held", 16'(held0), 16'h0);
        chk("rel9_row3", 16'(rs0), 16'h7);

        // Bounce: 2 low, 1 high, 4 low -> one pulse on the last sample.
        vld_seen = 0;
        tick(1'b1, 4'b1110, 1'b0);
        tick(1'b1, 4'b1110, 1'b0);
        tick(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b1110, 1'b0);
        chk("bounce_early", 16'(vld_seen), 16'h0);
        tick(1'b1, 4'b1110, 1'b0);
        chk("bounce_last", 16'(vld0), 16'h1);
        chk("bounce_pulses", 16'(vld_seen), 16'h1);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'hF, 1'b0);

        // Two columns low on row 1 -> lowest column, code 4; reset during HELD.
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0110, 1'b0);
        chk("multi_code4", 16'(code0), 16'h4);
        tick(1'b1, 4'b0110, 1'b0);
        do_reset();
        chk("hold_rst_held", 16'(held0), 16'h0);
        chk("hold_rst_row", 16'(rs0), 16'hE);
        chk("hold_rst_val", val0, 16'h0);

        // Accumulator: keys 1..5 shift in, oldest digit drops out.
        for (int key = 1; key <= 5; key++) begin
            press(key);
            release_key();
        end
`ifdef KEYPAD_ACCUM_EN
        chk("accum_2345", val0, 16'h2345);
`else
        chk("accum_off", val0, 16'h0);
`endif
        // clr in the key_vld cycle wins.
        press(6);
        tick(1'b0, 4'hF, 1'b1);
        chk("clr_priority", val0, 16'h0);
        release_key();

        // Reset mid-debounce abandons the key.
        tick(1'b1, 4'b1011, 1'b0);
        tick(1'b1, 4'b1011, 1'b0);
        do_reset();
        chk("deb_rst_code", 16'(code0), 16'h0);
        tick(1'b1, 4'hF, 1'b0);
        chk("deb_rst_row1", 16'(rs0), 16'hD);

        // Randomised traffic: physical keys, noise, gaps and clears.
        begin
            int cur_key;
            int r;
            bit s;
            cur_key = $urandom_range(0, 15);
            for (int n = 0; n < 400; n++) begin
                if (n % 25 == 0) cur_key = $urandom_range(0, 15);
                s = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                if (r < 5)      tick(s, phys(cur_key), ($urandom_range(0, 15) == 0));
                else if (r < 8) tick(s, 4'hF, ($urandom_range(0, 15) == 0));
                else            tick(s, 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
